// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed driver for N active-low seven-segment digits with per-frame input snapshot.
// Define SEVSEG_LZB_EN to enable leading-zero blanking.
module sevenseg_scan_driver #(
    parameter int unsigned N_DIGITS    = 8,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic                  hex_trigger,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic [6:0]            sevenSeg,
    output logic                  DP,
    output logic [N_DIGITS-1:0]   AN,
    output logic                  frame_done
);

    localparam int unsigned TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [TICK_W-1:0]     tick_cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] snap_value;
    logic                  snap_hex;
    logic [N_DIGITS-1:0]   snap_en;
    logic [N_DIGITS-1:0]   snap_dp;
    logic                  load_pending;

    logic                  slot_end;
    logic                  frame_end;
    logic [3:0]            digit_nib;
    logic                  digit_lit;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [N_DIGITS-1:0]   an_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib, input logic hex_mode);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        // Non-decimal nibbles in BCD mode show a lone G segment as an error mark
        if (!hex_mode && nib > 4'd9) begin
            seg = 7'b1111110;
        end
        return seg;
    endfunction

    always_comb begin
        slot_end  = (tick_cnt == TICK_LAST);
        frame_end = slot_end && (idx == IDX_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            idx      <= '0;
        end else if (slot_end) begin
            tick_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Inputs are captured once per frame (and once right after reset) so a frame never tears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_value   <= '0;
            snap_hex     <= 1'b0;
            snap_en      <= '0;
            snap_dp      <= '0;
            load_pending <= 1'b1;
        end else begin
            if (load_pending || frame_end) begin
                snap_value <= value;
                snap_hex   <= hex_trigger;
                snap_en    <= digit_en;
                snap_dp    <= dp_in;
            end
            load_pending <= 1'b0;
        end
    end

    always_comb begin
        digit_nib = snap_value[{idx, 2'b00} +: 4];
    end

`ifdef SEVSEG_LZB_EN
    logic [N_DIGITS-1:0] blank;

    // Walk down from the top digit; a nonzero nibble or a requested DP ends the blank run
    always_comb begin
        logic        scanning;
        int unsigned k;
        blank    = '0;
        scanning = 1'b1;
        k        = 0;
        for (int unsigned i = 1; i < N_DIGITS; i++) begin
            k = N_DIGITS - i;
            if (scanning && (snap_value[4*k +: 4] == 4'h0) && !snap_dp[k]) begin
                blank[k] = 1'b1;
            end else begin
                scanning = 1'b0;
            end
        end
    end

    always_comb begin
        digit_lit = snap_en[idx] && !blank[idx];
    end
`else
    always_comb begin
        digit_lit = snap_en[idx];
    end
`endif

    always_comb begin
        seg_next = 7'b1111111;
        dp_next  = 1'b1;
        an_next  = '1;
        if (digit_lit) begin
            seg_next     = seg_decode(digit_nib, snap_hex);
            dp_next      = ~snap_dp[idx];
            an_next[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sevenSeg   <= 7'b1111111;
            DP         <= 1'b1;
            AN         <= '1;
            frame_done <= 1'b0;
        end else begin
            sevenSeg   <= seg_next;
            DP         <= dp_next;
            AN         <= an_next;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed scoreboard bench for sevenseg_scan_driver (4 digits, 4 cycles per digit).
// Leading-zero expectations follow SEVSEG_LZB_EN.
module tb_sevenseg_scan_driver;

    localparam int unsigned ND = 4;
    localparam int unsigned RD = 4;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0000100, SA = 7'b0001000, SB = 7'b1100000;
    localparam logic [6:0] SF = 7'b0111000, DASH = 7'b1111110;

`ifdef SEVSEG_LZB_EN
    localparam logic [3:0] LIT_0040 = 4'b0011;
    localparam logic [3:0] LIT_ZERO = 4'b0001;
`else
    localparam logic [3:0] LIT_0040 = 4'b1111;
    localparam logic [3:0] LIT_ZERO = 4'b1111;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value;
    logic        hex_trigger;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic [6:0]  sevenSeg;
    logic        DP;
    logic [3:0]  AN;
    logic        frame_done;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    typedef struct {
        string      tag;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t sb[$];

    sevenseg_scan_driver #(
        .N_DIGITS   (ND),
        .REFRESH_DIV(RD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .hex_trigger(hex_trigger),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .sevenSeg   (sevenSeg),
        .DP         (DP),
        .AN         (AN),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_an"},  {4'b0, AN},         8'h0F);
        chk({tag, "_seg"}, {1'b0, sevenSeg},   8'h7F);
        chk({tag, "_dp"},  {7'b0, DP},         8'h01);
        chk({tag, "_fd"},  {7'b0, frame_done}, 8'h00);
    endtask

    // Pushes one frame of expectations for the given snapshot, then pops one per cycle.
    // Next-frame inputs are driven mid-frame so they must not affect this frame.
    task automatic run_frame(input string tag, input logic [27:0] segs, input logic [3:0] lit,
                             input logic [3:0] dpreq, input bit first, input int ncyc,
                             input logic [15:0] nv, input logic nh, input logic [3:0] nen,
                             input logic [3:0] ndp);
        exp_t e;
        for (int c = 0; c < ncyc; c++) begin
            int d;
            d     = c / 4;
            e.tag = $sformatf("%s_c%0d", tag, c);
            if ((first && c == 0) || !lit[d]) begin
                e.an  = 4'hF;
                e.seg = 7'b1111111;
                e.dp  = 1'b1;
            end else begin
                e.an  = ~(4'b0001 << d);
                e.seg = segs[7*d +: 7];
                e.dp  = ~dpreq[d];
            end
            e.fd = (c == 15);
            sb.push_back(e);
        end
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk({e.tag, "_an"},  {4'b0, AN},         {4'b0, e.an});
            chk({e.tag, "_seg"}, {1'b0, sevenSeg},   {1'b0, e.seg});
            chk({e.tag, "_dp"},  {7'b0, DP},         {7'b0, e.dp});
            chk({e.tag, "_fd"},  {7'b0, frame_done}, {7'b0, e.fd});
            if (c == 7) begin
                value       = nv;
                hex_trigger = nh;
                digit_en    = nen;
                dp_in       = ndp;
            end
        end
    endtask

    initial begin
        value       = 16'h1234;
        hex_trigger = 1'b1;
        digit_en    = 4'hF;
        dp_in       = 4'h0;
        reset       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_dark("rst_init");
        @(negedge clk);
        reset = 1'b0;

        run_frame("f0_1234", {S1, S2, S3, S4}, 4'hF, 4'h0, 1'b1, 16, 16'hAB9F, 1'b1, 4'hF, 4'h0);
        run_frame("f1_hex",  {SA, SB, S9, SF}, 4'hF, 4'h0, 1'b0, 16, 16'hAB9F, 1'b0, 4'hF, 4'h0);
        run_frame("f2_bcd",  {DASH, DASH, S9, DASH}, 4'hF, 4'h0, 1'b0, 16, 16'h1111, 1'b1, 4'hF, 4'h0);
        run_frame("f3_tear", {S1, S1, S1, S1}, 4'hF, 4'h0, 1'b0, 16, 16'h2222, 1'b1, 4'hF, 4'h0);
        run_frame("f4_2222", {S2, S2, S2, S2}, 4'hF, 4'h0, 1'b0, 16, 16'h5678, 1'b1, 4'b0101, 4'b0001);
        run_frame("f5_endp", {S5, S6, S7, S8}, 4'b0101, 4'b0001, 1'b0, 16, 16'h0040, 1'b1, 4'hF, 4'h0);
        run_frame("f6_0040", {S0, S0, S4, S0}, LIT_0040, 4'h0, 1'b0, 16, 16'h0000, 1'b1, 4'hF, 4'h0);
        run_frame("f7_zero", {S0, S0, S0, S0}, LIT_ZERO, 4'h0, 1'b0, 16, 16'h5678, 1'b1, 4'hF, 4'h0);
        run_frame("f8_pre",  {S5, S6, S7, S8}, 4'hF, 4'h0, 1'b0, 9, 16'h5678, 1'b1, 4'hF, 4'h0);

        // Reset lands mid-cycle inside digit 2's slot; outputs must go dark without a clock edge
        #2;
        reset = 1'b1;
        #1;
        chk_dark("rst_async");
        value = 16'h9876;
        repeat (2) @(posedge clk);
        #1;
        chk_dark("rst_hold");
        @(negedge clk);
        reset = 1'b0;

        run_frame("f9_restart", {S9, S8, S7, S6}, 4'hF, 4'h0, 1'b1, 16, 16'h9876, 1'b1, 4'hF, 4'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
